ssp_tx_ctrl: RTL and testbench



---
 rtl/ssp_pkg.sv | 24 ++
 rtl/ssp_clk_div.sv | 61 ++++++
 rtl/ssp_tx_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ssp_tx_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared types and constants for the SSP transmit path
// Holds the transmit FSM state type, default frame width and divider
// setting, and the bit-counter width helper used by ssp_tx_ctrl.
package ssp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_SYNC  = 3'd3,
        S_SHIFT = 3'd4
    } ssp_tx_state_t;

    localparam int SSP_DATA_W      = 8;
    localparam int SSP_DEF_CLK_DIV = 1;

    // One spare bit so the counter can hold DATA_W itself without wrapping.
    function automatic int ssp_bcnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int SSP_BCNT_W = ssp_bcnt_w(SSP_DATA_W);

endpackage

// File: rtl/ssp_clk_div.sv
// rtl/ssp_clk_div.sv - SSPCLKOUT half-period divider for the transmit sequencer
// Ports:
//   i_clk       system clock (PCLK)
//   i_rst       asynchronous active-high reset
//   i_run       high when the next cycle belongs to a SYNC or SHIFT period
//   o_half_tick strobe in the last cycle of the high half of a period
//   o_bit_tick  strobe in the last cycle of a full period (end of bit)
//   o_sclk      registered serial clock level, high for the first half
module ssp_clk_div
    import ssp_pkg::*;
#(
    parameter int CLK_DIV = SSP_DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_half_tick,
    output logic o_bit_tick,
    output logic o_sclk
);

    localparam logic [8:0] HALF      = 9'(CLK_DIV);
    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] LAST      = 9'(2 * CLK_DIV - 1);

    logic [8:0] r_cnt;
    logic       r_run;
    logic       r_sclk;
    logic [8:0] w_cnt_next;
    logic       w_sclk_next;

    // i_run looks one cycle ahead, so the count and clock level are already
    // correct in the first cycle of an active period.
    always_comb begin
        w_cnt_next  = '0;
        w_sclk_next = 1'b0;
        if (i_run) begin
            if (r_run && (r_cnt != LAST)) begin
                w_cnt_next = r_cnt + 9'd1;
            end
            w_sclk_next = (w_cnt_next < HALF);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_run  <= i_run;
            r_sclk <= w_sclk_next;
        end
    end

    assign o_half_tick = r_run && (r_cnt == HALF_LAST);
    assign o_bit_tick  = r_run && (r_cnt == LAST);
    assign o_sclk      = r_sclk;

endmodule

// File: rtl/ssp_tx_ctrl.sv
// rtl/ssp_tx_ctrl.sv - SSP transmit sequencer: FIFO pop handshake and MSB-first TI-SSI framing
// Optional feature macro: SSP_TX_IDLE_INTR_EN (adds SSPTXIDLEINTR drained-FIFO pulse).
// Ports:
//   PCLK              system clock
//   CLEAR             asynchronous active-high reset
//   SSE               serial enable (level)
//   tx_ready          FIFO data strobe, TxData valid while high
//   TxData            byte from the TX FIFO
//   transmit_complete one-cycle pop request to the FIFO
//   SSPTXD            serial data, MSB first
//   SSPCLKOUT         serial clock, idle low
//   SSPFSSOUT         frame-sync pulse, active high
//   SSPOE_B           pad output enable, active low
//   busy              high whenever the sequencer is not idle
//   SSPTXIDLEINTR     (optional) FIFO-drained pulse
module ssp_tx_ctrl
    import ssp_pkg::*;
#(
    parameter int DATA_W      = SSP_DATA_W,
    parameter int CLK_DIV     = SSP_DEF_CLK_DIV,
    parameter int REQ_TIMEOUT = 4
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic              SSE,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] TxData,
    output logic              transmit_complete,
    output logic              SSPTXD,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPOE_B,
    output logic              busy
`ifdef SSP_TX_IDLE_INTR_EN
    ,
    output logic              SSPTXIDLEINTR
`endif
);

    localparam int                BCNT_W   = ssp_bcnt_w(DATA_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
    localparam logic [3:0]        TO_LIM   = 4'(REQ_TIMEOUT);

    ssp_tx_state_t     r_state;
    ssp_tx_state_t     w_state_next;
    logic [3:0]        r_to_cnt;
    logic [3:0]        w_to_cnt_next;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic [BCNT_W-1:0] w_bit_cnt_next;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_next;

    logic r_tc;
    logic r_txd;
    logic r_fss;
    logic r_oe_b;
    logic r_busy;

    logic w_half_tick;
    logic w_bit_tick;
    logic w_sclk;
    logic w_run_next;

    ssp_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .i_clk       (PCLK),
        .i_rst       (CLEAR),
        .i_run       (w_run_next),
        .o_half_tick (w_half_tick),
        .o_bit_tick  (w_bit_tick),
        .o_sclk      (w_sclk)
    );

    always_comb begin
        w_state_next   = r_state;
        w_to_cnt_next  = r_to_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shreg_next   = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (SSE) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next  = S_WAIT;
                w_to_cnt_next = '0;
            end
            S_WAIT: begin
                // A byte arriving as SSE drops is still sent, so tx_ready wins.
                if (tx_ready) begin
                    w_shreg_next  = TxData;
                    w_state_next  = S_SYNC;
                    w_to_cnt_next = '0;
                end else if (!SSE) begin
                    w_state_next  = S_IDLE;
                    w_to_cnt_next = '0;
                end else if ((r_to_cnt + 4'd1) == TO_LIM) begin
                    w_state_next  = S_REQ;
                    w_to_cnt_next = '0;
                end else begin
                    w_to_cnt_next = r_to_cnt + 4'd1;
                end
            end
            S_SYNC: begin
                if (w_bit_tick) begin
                    w_state_next   = S_SHIFT;
                    w_bit_cnt_next = '0;
                end
            end
            S_SHIFT: begin
                if (w_bit_tick) begin
                    w_shreg_next = {r_shreg[DATA_W-2:0], 1'b0};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = SSE ? S_REQ : S_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_run_next = (w_state_next == S_SYNC) || (w_state_next == S_SHIFT);

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state   <= S_IDLE;
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_tc      <= 1'b0;
            r_txd     <= 1'b0;
            r_fss     <= 1'b0;
            r_oe_b    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_to_cnt  <= w_to_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shreg   <= w_shreg_next;
            // Outputs are decoded from the next state so they line up with it.
            r_tc      <= (w_state_next == S_REQ);
            r_fss     <= (w_state_next == S_SYNC);
            r_oe_b    <= !w_run_next;
            r_txd     <= w_run_next && w_shreg_next[DATA_W-1];
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    // The half and full period strobes can never coincide.
    assert property (@(posedge PCLK) disable iff (CLEAR) !(w_half_tick && w_bit_tick));

    assign transmit_complete = r_tc;
    assign SSPTXD            = r_txd;
    assign SSPCLKOUT         = w_sclk;
    assign SSPFSSOUT         = r_fss;
    assign SSPOE_B           = r_oe_b;
    assign busy              = r_busy;

`ifdef SSP_TX_IDLE_INTR_EN
    logic r_drained;
    logic r_idle_intr;
    logic w_timeout;
    logic w_latch;
    logic w_frame_end;

    assign w_timeout   = (r_state == S_WAIT)  && (w_state_next == S_REQ);
    assign w_latch     = (r_state == S_WAIT)  && (w_state_next == S_SYNC);
    assign w_frame_end = (r_state == S_SHIFT) && (w_state_next != S_SHIFT);

    // Armed by a finished frame, fires once on the next retry, then waits
    // for another byte to be latched.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_drained   <= 1'b0;
            r_idle_intr <= 1'b0;
        end else begin
            r_idle_intr <= w_timeout && r_drained;
            if (w_latch || w_timeout) begin
                r_drained <= 1'b0;
            end else if (w_frame_end) begin
                r_drained <= 1'b1;
            end
        end
    end

    assign SSPTXIDLEINTR = r_idle_intr;
`endif

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// tb/tb_ssp_tx_ctrl.sv - self-checking bench for ssp_tx_ctrl (CLK_DIV=1 and CLK_DIV=2 instances)
module tb_ssp_tx_ctrl;

    logic PCLK = 1'b0;
    logic CLEAR;
    always #5 PCLK = ~PCLK;

    logic       sse1, rdy1, tc1, txd1, sclk1, fss1, oeb1, busy1;
    logic [7:0] dat1;
    logic       sse2, rdy2, tc2, txd2, sclk2, fss2, oeb2, busy2;
    logic [7:0] dat2;
`ifdef SSP_TX_IDLE_INTR_EN
    logic       intr1, intr2;
`endif

    ssp_tx_ctrl #(.DATA_W(8), .CLK_DIV(1), .REQ_TIMEOUT(4)) dut1 (
        .PCLK(PCLK), .CLEAR(CLEAR), .SSE(sse1), .tx_ready(rdy1), .TxData(dat1),
        .transmit_complete(tc1), .SSPTXD(txd1), .SSPCLKOUT(sclk1),
        .SSPFSSOUT(fss1), .SSPOE_B(oeb1), .busy(busy1)
`ifdef SSP_TX_IDLE_INTR_EN
        , .SSPTXIDLEINTR(intr1)
`endif
    );

    ssp_tx_ctrl #(.DATA_W(8), .CLK_DIV(2), .REQ_TIMEOUT(4)) dut2 (
        .PCLK(PCLK), .CLEAR(CLEAR), .SSE(sse2), .tx_ready(rdy2), .TxData(dat2),
        .transmit_complete(tc2), .SSPTXD(txd2), .SSPCLKOUT(sclk2),
        .SSPFSSOUT(fss2), .SSPOE_B(oeb2), .busy(busy2)
`ifdef SSP_TX_IDLE_INTR_EN
        , .SSPTXIDLEINTR(intr2)
`endif
    );

    // FIFO models: a request seen in one cycle produces tx_ready for the
    // whole following cycle.
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    bit pend1 = 0, pend2 = 0;

    always @(negedge PCLK) begin
        rdy1 = pend1;
        pend1 = 0;
        if (tc1 && q1.size() > 0) begin
            dat1 = q1.pop_front();
            pend1 = 1;
        end
        rdy2 = pend2;
        pend2 = 0;
        if (tc2 && q2.size() > 0) begin
            dat2 = q2.pop_front();
            pend2 = 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {transmit_complete, SSPFSSOUT, SSPCLKOUT, SSPTXD, SSPOE_B, busy}
    function automatic logic [5:0] outs1();
        return {tc1, fss1, sclk1, txd1, oeb1, busy1};
    endfunction
    function automatic logic [5:0] outs2();
        return {tc2, fss2, sclk2, txd2, oeb2, busy2};
    endfunction

    typedef struct {
        logic       sse;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[22];

    logic cap_oe[100];
    logic cap_txd[100];
    logic cap_clk[100];
    logic cap_fss[100];

    task automatic check_frame(input int s, input int e, input logic [7:0] b, input string tag);
        int clk_err;
        int fss_err;
        if (s < 0 || e < 0) begin
            chk({tag, "_found"}, 32'd0, 32'd1);
        end else begin
            clk_err = 0;
            fss_err = 0;
            chk({tag, "_len"}, 32'(e - s), 32'd36);
            for (int k = 0; k < 8; k++) begin
                if (s + 4 + 4 * k < 100)
                    chk($sformatf("%s_bit%0d", tag, 7 - k), 32'(cap_txd[s + 4 + 4 * k]), 32'(b[7 - k]));
            end
            for (int o = 0; o < 36 && s + o < 100; o++) begin
                if (cap_clk[s + o] !== ((o % 4) < 2)) clk_err++;
                if (cap_fss[s + o] !== (o < 4)) fss_err++;
            end
            chk({tag, "_clk_err"}, 32'(clk_err), 32'd0);
            chk({tag, "_fss_err"}, 32'(fss_err), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        int last, npulse, oe_err, ntc, oe_low, rises, txd_bad;
        bit found, prev_clk;
        int s1, e1, s2, e2;

        CLEAR = 1'b1;
        sse1 = 0; sse2 = 0; rdy1 = 0; rdy2 = 0; dat1 = 0; dat2 = 0;

        // Vector table: single 0xA5 frame at CLK_DIV=1, SSE dropped in WAIT
        // while tx_ready arrives (byte must still be sent).
        a5 = 8'hA5;
        tbl[0] = '{1'b1, 6'b100011};
        tbl[1] = '{1'b0, 6'b000011};
        tbl[2] = '{1'b0, 6'b011101};
        tbl[3] = '{1'b0, 6'b010101};
        for (int k = 0; k < 8; k++) begin
            tbl[4 + 2 * k] = '{1'b0, {3'b001, a5[7 - k], 2'b01}};
            tbl[5 + 2 * k] = '{1'b0, {3'b000, a5[7 - k], 2'b01}};
        end
        tbl[20] = '{1'b0, 6'b000010};
        tbl[21] = '{1'b0, 6'b000010};

        repeat (3) @(negedge PCLK);
        chk("reset_dut1", 32'(outs1()), 32'h02);
        chk("reset_dut2", 32'(outs2()), 32'h02);
`ifdef SSP_TX_IDLE_INTR_EN
        chk("reset_intr1", 32'(intr1), 32'd0);
`endif
        CLEAR = 1'b0;
        repeat (2) @(negedge PCLK);

        // Empty FIFO: request every REQ_TIMEOUT+1 cycles, pads never enabled.
        sse1 = 1;
        last = -1; npulse = 0; oe_err = 0; ntc = 0;
        for (int c = 0; c < 23; c++) begin
            @(negedge PCLK);
            if (tc1) begin
                if (last >= 0) chk("req_period", 32'(c - last), 32'd5);
                last = c;
                npulse++;
            end
            if (!oeb1) oe_err++;
`ifdef SSP_TX_IDLE_INTR_EN
            if (intr1) ntc++;
`endif
        end
        chk("empty_pulses", 32'(npulse), 32'd5);
        chk("empty_oe", 32'(oe_err), 32'd0);
`ifdef SSP_TX_IDLE_INTR_EN
        chk("intr_before_frame", 32'(ntc), 32'd0);
`endif
        sse1 = 0;
        repeat (3) @(negedge PCLK);
        chk("idle_after_empty", 32'(outs1()), 32'h02);

        // Table-driven single frame.
        q1.push_back(8'hA5);
        for (int i = 0; i < 22; i++) begin
            @(negedge PCLK);
            if (i > 0) chk($sformatf("frame_row%0d", i - 1), 32'(outs1()), 32'(tbl[i - 1].exp));
            sse1 = tbl[i].sse;
        end
        @(negedge PCLK);
        chk("frame_row21", 32'(outs1()), 32'(tbl[21].exp));

        // 0xFF with SSE dropped at bit 3: whole frame sent, then idle.
        q1.push_back(8'hFF);
        sse1 = 1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge PCLK);
            if (fss1) found = 1;
        end
        chk("ff_start", 32'(found), 32'd1);
        oe_low = 0; rises = 0; txd_bad = 0; ntc = 0; prev_clk = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge PCLK);
            if (!oeb1) begin
                oe_low++;
                if (txd1 !== 1'b1) txd_bad++;
            end
            if (sclk1 && !prev_clk) rises++;
            prev_clk = sclk1;
            if (tc1) ntc++;
            if (c == 8) sse1 = 0;
        end
        chk("ff_oe_low", 32'(oe_low), 32'd18);
        chk("ff_clk_rises", 32'(rises), 32'd9);
        chk("ff_txd_bad", 32'(txd_bad), 32'd0);
        chk("ff_no_req", 32'(ntc), 32'd0);
        chk("ff_idle", 32'(busy1), 32'd0);

        // Back-to-back 0x3C, 0xC3 at CLK_DIV=2.
        q2.push_back(8'h3C);
        q2.push_back(8'hC3);
        sse2 = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge PCLK);
            cap_oe[c] = oeb2;
            cap_txd[c] = txd2;
            cap_clk[c] = sclk2;
            cap_fss[c] = fss2;
        end
        sse2 = 0;
        s1 = -1; e1 = -1; s2 = -1; e2 = -1;
        for (int c = 0; c < 100; c++) begin
            if (!cap_oe[c]) begin
                if (s1 < 0) s1 = c;
                else if (e1 >= 0 && s2 < 0) s2 = c;
            end else begin
                if (s1 >= 0 && e1 < 0) e1 = c;
                else if (s2 >= 0 && e2 < 0) e2 = c;
            end
        end
        check_frame(s1, e1, 8'h3C, "b2b_f1");
        check_frame(s2, e2, 8'hC3, "b2b_f2");
        chk("b2b_gap", 32'((s2 >= 0 && e1 >= 0) && (s2 - e1 >= 2)), 32'd1);

        // Asynchronous CLEAR pulse in the middle of SHIFT.
        q1.push_back(8'h81);
        sse1 = 1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge PCLK);
            if (fss1) found = 1;
        end
        chk("rst_frame_start", 32'(found), 32'd1);
        repeat (4) @(negedge PCLK);
        sse1 = 0;
        chk("rst_in_shift", 32'(oeb1), 32'd0);
        #2 CLEAR = 1'b1;
        #1 chk("async_reset_hi", 32'(outs1()), 32'h02);
        CLEAR = 1'b0;
        #1 chk("async_reset_lo", 32'(outs1()), 32'h02);
        @(negedge PCLK);
        chk("reset_then_idle", 32'(outs1()), 32'h02);

`ifdef SSP_TX_IDLE_INTR_EN
        // One byte, then drained FIFO: exactly one interrupt at first retry.
        begin
            int end_c, first, n, no_tc, early;
            bit seen;
            end_c = -1; first = -1; n = 0; no_tc = 0; early = 0; seen = 0;
            q1.push_back(8'h5A);
            sse1 = 1;
            for (int c = 0; c < 45; c++) begin
                @(negedge PCLK);
                if (!oeb1) seen = 1;
                if (seen && oeb1 && end_c < 0) end_c = c;
                if (intr1) begin
                    n++;
                    if (first < 0) first = c;
                    if (!tc1) no_tc++;
                    if (end_c < 0) early++;
                end
            end
            sse1 = 0;
            chk("intr_count", 32'(n), 32'd1);
            chk("intr_cycle", 32'(first), 32'(end_c + 5));
            chk("intr_with_req", 32'(no_tc), 32'd0);
            chk("intr_early", 32'(early), 32'd0);
        end
`endif

        repeat (3) @(negedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
